// File: rtl/prm_edge_chk_sched.sv
// Sweeps the PRM edge-checker array one bank at a time for a latched occupancy code,
// streaming each bank's blocked-edge word downstream and totalling blocked edges.
module prm_edge_chk_sched #(
  parameter int BANK_W     = 32,
  parameter int NUM_BANKS  = 32,
  parameter int BANK_IDX_W = 5,
  parameter int CNT_W      = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  q_valid,
  output logic                  q_ready,
  input  logic [14:0]           q_code,
  input  logic                  q_abort,
  output logic [14:0]           chk_code,
  output logic [BANK_IDX_W-1:0] chk_bank,
  input  logic [BANK_W-1:0]     chk_mask,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [BANK_W-1:0]     r_data,
  output logic [BANK_IDX_W-1:0] r_bank,
  output logic                  r_last,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      blk_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_OUT     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [BANK_IDX_W-1:0] LAST_BANK = BANK_IDX_W'(NUM_BANKS - 1);

  state_t r_state;

  function automatic logic [CNT_W-1:0] popcount(input logic [BANK_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < BANK_W; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Query sequencer: state, checker drive, result word and blocked count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      q_ready  <= 1'b1;
      chk_code <= 15'd0;
      chk_bank <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_bank   <= '0;
      r_last   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      blk_cnt  <= '0;
    end else begin
      done <= 1'b0;
      // Abort beats every other transition; the partial count is kept
      if ((r_state != S_IDLE) && q_abort) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        busy    <= 1'b0;
        q_ready <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (q_valid && q_ready) begin
              chk_code <= q_code;
              chk_bank <= '0;
              blk_cnt  <= '0;
              q_ready  <= 1'b0;
              busy     <= 1'b1;
              r_state  <= S_ISSUE;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_ISSUE: begin
            r_state <= S_CAPTURE;
          end
          S_CAPTURE: begin
            r_data  <= chk_mask;
            r_bank  <= chk_bank;
            r_last  <= (chk_bank == LAST_BANK);
            r_valid <= 1'b1;
            blk_cnt <= blk_cnt + popcount(chk_mask);
            r_state <= S_OUT;
          end
          S_OUT: begin
            if (r_ready) begin
              r_valid <= 1'b0;
              if (r_last) begin
                done    <= 1'b1;
                r_state <= S_DONE;
              end else begin
                chk_bank <= chk_bank + BANK_IDX_W'(1);
                r_state  <= S_ISSUE;
              end
            end else begin
              r_state <= S_OUT;
            end
          end
          S_DONE: begin
            busy    <= 1'b0;
            q_ready <= 1'b1;
            r_state <= S_IDLE;
          end
          default: begin
            r_valid <= 1'b0;
            busy    <= 1'b0;
            q_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/prm_edge_chk_sched.md
Name: prm_edge_chk_sched

Overview:
- Sequences the per-edge obstacle-check logic (one combinational checker per roadmap edge, 15-bit occupancy code A..O in, edge_mask out) across the whole PRM roadmap.
- Latches one 15-bit occupancy code per query and sweeps the checker array one bank of BANK_W edges at a time.
- Streams each bank's blocked-edge word to the planner over a valid/ready handshake and accumulates a total blocked-edge count.
- Sits between the occupancy encoder (upstream) and the roadmap edge-weight updater (downstream).

Parameters:
BANK_W, 32, edges per checker bank (width of chk_mask and r_data)
NUM_BANKS, 32, number of banks swept per query (total edges = BANK_W*NUM_BANKS)
BANK_IDX_W, 5, width of bank index, equals clog2(NUM_BANKS)
CNT_W, 11, blocked-count width, equals clog2(BANK_W*NUM_BANKS+1)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
q_valid  input  1  query request valid
q_ready  output  1  scheduler can accept a query
q_code  input  15  occupancy code; bit0=A ... bit14=O
q_abort  input  1  cancel the current query
chk_code  output  15  code driven to all checkers; stable for the whole query
chk_bank  output  BANK_IDX_W  bank select for the checker mux
chk_mask  input  BANK_W  edge_mask outputs of the selected bank; 1 = edge blocked
r_valid  output  1  result word valid
r_ready  input  1  downstream accepts result word
r_data  output  BANK_W  registered chk_mask of bank r_bank
r_bank  output  BANK_IDX_W  bank index of r_data
r_last  output  1  r_data belongs to bank NUM_BANKS-1
busy  output  1  query in progress (any state except IDLE)
done  output  1  one-cycle pulse when a query completes normally
blk_cnt  output  CNT_W  running sum of blocked edges for the current or last query

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 (chk_code, chk_bank, r_*, blk_cnt, done, busy), except q_ready=1.
- q_ready=1 only in IDLE. A query is accepted when q_valid&q_ready at a rising edge. On acceptance: chk_code<=q_code, chk_bank<=0, blk_cnt<=0, go to ISSUE.
- States:
  - IDLE: waits for a query.
  - ISSUE: chk_bank is stable for one settling cycle; go to CAPTURE.
  - CAPTURE: at the edge, r_data<=chk_mask, r_bank<=chk_bank, r_last<=(chk_bank==NUM_BANKS-1), r_valid<=1, blk_cnt<=blk_cnt+popcount(chk_mask); go to OUT.
  - OUT: holds r_* stable while r_valid&!r_ready.
    - On r_valid&r_ready with r_last=0: r_valid<=0, chk_bank<=chk_bank+1, go to ISSUE.
    - On r_valid&r_ready with r_last=1: r_valid<=0, go to DONE.
  - DONE: done=1 for exactly this cycle; go to IDLE.
- chk_bank must not change while in ISSUE or CAPTURE; the checker mux is purely combinational, so one full cycle of settling is guaranteed before sampling.
- Minimum per-bank cost is 3 cycles (ISSUE, CAPTURE, OUT with r_ready=1). Minimum query length is 3*NUM_BANKS+1 cycles from acceptance to done (97 cycles at defaults).
- chk_bank never exceeds NUM_BANKS-1; there is no wrap within a query. It is reset to 0 only on query acceptance and holds its last value in IDLE.
- blk_cnt cannot overflow (CNT_W is sized for all edges blocked). It holds its final value after done until the next acceptance.
- q_abort is sampled in any non-IDLE state and has priority over all other transitions: next state IDLE, r_valid<=0, no done pulse, blk_cnt holds its partial value. A word in OUT that is accepted (r_ready=1) in the same cycle as q_abort still counts as transferred. q_abort in IDLE is ignored.
- q_valid while busy is not accepted (q_ready=0); the upstream holds it.
- Reset mid-query: immediate return to the reset state; no done pulse.
- r_ready may toggle freely. r_data, r_bank and r_last must not change while r_valid=1 and the word is not accepted.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> q_ready=1, busy=0, r_valid=0, blk_cnt=0 for 10 cycles with q_valid=0.
- Full sweep, r_ready=1, checker stub chk_mask=32'h0000_0001<<chk_bank, q_code=15'h4A31 -> chk_code=15'h4A31 throughout; 32 words with r_bank 0..31 and r_data=1<<r_bank; r_last only on bank 31; done pulse 97 cycles after acceptance; blk_cnt=32.
- Backpressure: stub chk_mask=32'hFFFF_FFFF, r_ready low for 5 cycles on bank 3 -> r_data/r_bank held stable; sweep completes; final blk_cnt=1024 (no overflow).
- Abort: q_abort pulsed while r_valid=1 on bank 7 with r_ready=0 -> next cycle IDLE, r_valid=0, q_ready=1, no done pulse; blk_cnt equals popcount total of banks 0..7.
- Query while busy: q_valid held high with a second code 15'h0001 during a sweep -> not accepted until the cycle after done; new sweep starts with chk_bank=0, blk_cnt cleared.
- Async reset mid-sweep at bank 12: rst_n low asynchronously -> all outputs 0 immediately (q_ready=1 after release); no done pulse.
